mips32_prog_loader: RTL and testbench
=====================================

Name: mips32_prog_loader

Overview:
Upstream loader for the mips32 core. It accepts a byte stream through a valid/ready handshake and packs it into 32-bit big-endian words. It writes the words into the core's unified instruction/data memory through a single write port. It holds the core stalled until a complete, checksum-verified image is in memory, then releases it. This replaces the hand-written memory and PC initialisation used in simulation.

Parameters:
ADDR_W, 10, memory word-address width (1024 words)
DATA_W, 32, memory word width; fixed at 32, other values unsupported

Ports:
clk1  in  1  single system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input byte valid
s_ready  out  1  loader accepts byte this cycle
s_data  in  8  input byte
clear  in  1  return from DONE/ERR to header reception
mem_we  out  1  memory write strobe, one cycle per word
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
cpu_run  out  1  1 = core may run (pc=0, halted=0 released); 0 = hold core
busy  out  1  image transfer in progress (past first header byte)
done  out  1  image loaded and verified
err  out  1  header range error or checksum mismatch

Behaviour:
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, busy=0, done=0, err=0. State=HDR, byte counters=0, checksum=0.
- Byte transfer occurs when s_valid & s_ready. s_ready=1 in HDR, DATA, CSUM. s_ready=0 in DONE and ERR, and in the first cycle after reset release.
- Stream format, all fields big-endian:
  - 2-byte start word address A.
  - 2-byte word count N.
  - N x 4-byte words.
  - 1 checksum byte equal to the XOR of all 4N payload bytes. Header bytes are excluded from the checksum.
- HDR: collects 4 bytes. On the 4th byte:
  - if A >= 2^ADDR_W, or A+N > 2^ADDR_W (17-bit compare, no wrap-around), go to ERR;
  - else if N=0, go to CSUM;
  - else go to DATA.
- DATA: a 2-bit byte index packs bytes MSB-first. The cycle after the 4th byte of a word, mem_we=1 for exactly one cycle, with mem_addr = A+k (k = word index from 0) and mem_wdata = the packed word. mem_addr/mem_wdata hold their values until the next write. After word N-1 is accepted, go to CSUM. A new byte can be accepted in the same cycle as the write strobe, so sustained throughput is 1 byte/cycle.
- CSUM: one byte. If it equals the running XOR, go to DONE; else go to ERR.
- DONE: done=1, cpu_run=1 (registered, asserted the cycle after the checksum byte). The last mem_we is guaranteed to occur no later than the cycle cpu_run rises.
- ERR: err=1, cpu_run=0. Memory contents already written remain and are not rolled back.
- clear (in DONE or ERR): next cycle state=HDR, done=err=cpu_run=0, counters and checksum zeroed. clear is ignored in other states.
- busy=1 from acceptance of the first header byte until entry to DONE/ERR.
- s_valid with no handshake: state is untouched, so arbitrary gaps are allowed.
- rst_n low at any time, including mid-word: immediate return to reset values. A partially packed word is discarded and never written.
- Checksum and counters are cleared on entry to HDR.

Decomposition:
- Package mips32_loader_pkg:
  - state enum {HDR, DATA, CSUM, DONE, ERR};
  - HDR_BYTES=4, WORD_BYTES=4 constants;
  - a helper function for the range check.
- One natural sub-module: mips32_byte_packer (8-to-32 shift packer with byte index, word_valid pulse and a sync clear). The loader FSM, address counter and checksum stay in the top module.

Test Plan:
- Nominal load: bytes 00 00 00 02 | 28 0a 00 c8 | 28 02 00 01 | c1 -> mem_we at addr 0 = 280a00c8, addr 1 = 28020001. done=1, cpu_run=1, err=0, exactly 2 write strobes.
- Bad checksum: same stream with last byte c0 -> err=1, cpu_run=0, 2 writes performed. clear -> state HDR, err=0, s_ready=1.
- Zero count: 00 10 00 00 | 00 -> no mem_we, done=1. A checksum byte of 01 instead -> err=1.
- Range error: 03 ff 00 02 -> err=1 after 4th byte, no mem_we, s_ready=0. Boundary 03 fe 00 02 + 8 bytes + csum -> writes at 0x3fe and 0x3ff, done=1.
- Backpressure/gaps: nominal stream with random s_valid gaps (0-5 cycles) -> identical writes and done. No byte is accepted in DONE even with s_valid held high.
- Reset mid-word: assert rst_n=0 after 2 data bytes of word 1 -> all outputs at reset values, no write for the partial word. A subsequent full nominal load completes correctly.

Source files
------------

// File: rtl/mips32_loader_pkg.sv
// Shared types and helpers for the mips32 program loader: FSM states,
// stream framing constants and the header address-range check.
package mips32_loader_pkg;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    DATA = 3'd1,
    CSUM = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  // True when the image [a, a+n) does not fit in a 2^addr_w word memory.
  // Evaluated at 17 bits so a+n can never wrap back into range.
  function automatic logic range_err(input logic [15:0] a,
                                     input logic [15:0] n,
                                     input int          addr_w);
    logic [16:0] lim;
    logic [16:0] a17;
    logic [16:0] end17;
    lim   = 17'(1) << addr_w;
    a17   = {1'b0, a};
    end17 = a17 + {1'b0, n};
    return (a17 >= lim) || (end17 > lim);
  endfunction

endpackage

// File: rtl/mips32_byte_packer.sv
// Packs an 8-bit stream MSB-first into 32-bit words; emits a one-cycle
// word_valid pulse the cycle after the fourth byte, and holds the word.
module mips32_byte_packer
  import mips32_loader_pkg::*;
(
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_done,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_q,   idx_d;
  logic [23:0] acc_q,   acc_d;
  logic [31:0] word_q,  word_d;
  logic        valid_q, valid_d;

  assign word_done  = in_valid && (idx_q == 2'(WORD_BYTES - 1));
  assign word_valid = valid_q;
  assign word       = word_q;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    idx_d   = idx_q;
    acc_d   = acc_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clr) begin
      idx_d = '0;
      acc_d = '0;
    end else if (word_done) begin
      word_d  = {acc_q, in_data};
      valid_d = 1'b1;
      idx_d   = '0;
      acc_d   = '0;
    end else if (in_valid) begin
      acc_d = {acc_q[15:0], in_data};
      idx_d = idx_q + 2'd1;
    end
  end

  // NOTE: state flops use non-blocking assignment only; blocking here would
  // make the result depend on process evaluation order.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/mips32_prog_loader.sv
// Byte-stream program loader: parses header, writes payload words into core
// memory, verifies the XOR checksum and then releases the core.
module mips32_prog_loader
  import mips32_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e              state_q, state_d;
  logic                init_q;
  logic [1:0]          hdr_cnt_q, hdr_cnt_d;
  logic [23:0]         hdr_q, hdr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         words_left_q, words_left_d;
  logic [7:0]          csum_q, csum_d;
  logic                accept, pk_valid, pk_clr, pk_done, pk_we;
  logic [31:0]         pk_word, hdr_word;

  // init_q keeps s_ready low for the first cycle after reset release.
  assign s_ready  = init_q && (state_q == HDR || state_q == DATA || state_q == CSUM);
  assign accept   = s_valid && s_ready;
  assign pk_valid = accept && (state_q == DATA);
  assign hdr_word = {hdr_q, s_data};

  assign mem_we    = pk_we;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = pk_word;
  assign done      = (state_q == DONE);
  assign cpu_run   = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign busy      = (state_q == HDR && hdr_cnt_q != 2'd0) ||
                     state_q == DATA || state_q == CSUM;

  mips32_byte_packer u_packer (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .clr        (pk_clr),
    .in_valid   (pk_valid),
    .in_data    (s_data),
    .word_done  (pk_done),
    .word_valid (pk_we),
    .word       (pk_word)
  );

  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    hdr_d        = hdr_q;
    addr_d       = addr_q;
    mem_addr_d   = mem_addr_q;
    words_left_d = words_left_q;
    csum_d       = csum_q;
    pk_clr       = 1'b0;
    unique case (state_q)
      HDR: if (accept) begin
        if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
          hdr_cnt_d    = '0;
          addr_d       = hdr_word[16 +: ADDR_W];
          words_left_d = hdr_word[15:0];
          if (range_err(hdr_word[31:16], hdr_word[15:0], ADDR_W)) state_d = ERR;
          else if (hdr_word[15:0] == 16'd0)                        state_d = CSUM;
          else                                                     state_d = DATA;
        end else begin
          hdr_d     = {hdr_q[15:0], s_data};
          hdr_cnt_d = hdr_cnt_q + 2'd1;
        end
      end
      DATA: if (accept) begin
        csum_d = csum_q ^ s_data;
        if (pk_done) begin
          // Address is registered alongside the packer's write pulse.
          mem_addr_d   = addr_q;
          addr_d       = addr_q + ADDR_W'(1);
          words_left_d = words_left_q - 16'd1;
          if (words_left_q == 16'd1) state_d = CSUM;
        end
      end
      CSUM: if (accept) state_d = (s_data == csum_q) ? DONE : ERR;
      DONE, ERR: if (clear) begin
        state_d      = HDR;
        hdr_cnt_d    = '0;
        hdr_d        = '0;
        addr_d       = '0;
        words_left_d = '0;
        csum_d       = '0;
        pk_clr       = 1'b1;
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HDR;
      init_q       <= 1'b0;
      hdr_cnt_q    <= '0;
      hdr_q        <= '0;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      words_left_q <= '0;
      csum_q       <= '0;
    end else begin
      state_q      <= state_d;
      init_q       <= 1'b1;
      hdr_cnt_q    <= hdr_cnt_d;
      hdr_q        <= hdr_d;
      addr_q       <= addr_d;
      mem_addr_q   <= mem_addr_d;
      words_left_q <= words_left_d;
      csum_q       <= csum_d;
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Self-checking bench for mips32_prog_loader: directed and random image loads
// compared against a stream-level model of expected writes and outcome.
module tb_mips32_prog_loader;

  localparam int ADDR_W = 10;
  localparam int MEM_WORDS = 1 << ADDR_W;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [7:0]        s_data = 8'h00;
  logic              clear = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run, busy, done, err;

  int errors = 0;
  int checks = 0;
  logic [41:0] wq[$];
  logic [31:0] pay[16];

  mips32_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .clear     (clear),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk1 = ~clk1;

  // Every write strobe seen on the memory port, as {addr, data}.
  always @(negedge clk1)
    if (rst_n === 1'b1 && mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    bit ok;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    ok  = 1'b0;
    repeat (gap) @(negedge clk1);
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (s_ready === 1'b1) ok = 1'b1;
      @(negedge clk1);
    end
    s_valid = 1'b0;
    check("handshake", {63'b0, ok}, 64'd1);
  endtask

  // Send a whole image built from pay[0..n-1]; the checksum byte is XORed with
  // csum_flip so a nonzero flip produces a corrupt image.
  task automatic run_load(input logic [15:0] a, input int n,
                          input logic [7:0] csum_flip, input int max_gap);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [41:0] exp_q[$];
    bit          in_range;
    bit          exp_done;
    logic [15:0] n16;
    wq.delete();
    x        = 8'h00;
    n16      = 16'(n);
    in_range = (int'(a) < MEM_WORDS) && (int'(a) + n <= MEM_WORDS);
    check("busy_idle", {63'b0, busy}, 64'd0);
    send_byte(a[15:8], max_gap);
    check("busy_hdr", {63'b0, busy}, 64'd1);
    send_byte(a[7:0], max_gap);
    send_byte(n16[15:8], max_gap);
    send_byte(n16[7:0], max_gap);
    if (in_range) begin
      for (int k = 0; k < n; k++) begin
        for (int j = 0; j < 4; j++) begin
          b = pay[k][31 - 8*j -: 8];
          x = x ^ b;
          send_byte(b, max_gap);
        end
        exp_q.push_back({ADDR_W'(int'(a) + k), pay[k]});
      end
      send_byte(x ^ csum_flip, max_gap);
    end
    exp_done = in_range && (csum_flip == 8'h00);
    repeat (3) @(negedge clk1);
    check("done",    {63'b0, done},    {63'b0, exp_done});
    check("err",     {63'b0, err},     {63'b0, !exp_done});
    check("cpu_run", {63'b0, cpu_run}, {63'b0, exp_done});
    check("busy_end", {63'b0, busy},   64'd0);
    check("ready_end", {63'b0, s_ready}, 64'd0);
    check("write_count", 64'(wq.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      if (i < wq.size()) check("write", 64'(wq[i]), 64'(exp_q[i]));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk1);
    clear = 1'b0;
    check("clr_done",  {63'b0, done},    64'd0);
    check("clr_err",   {63'b0, err},     64'd0);
    check("clr_run",   {63'b0, cpu_run}, 64'd0);
    check("clr_ready", {63'b0, s_ready}, 64'd1);
    check("clr_busy",  {63'b0, busy},    64'd0);
  endtask

  task automatic set_nominal();
    pay[0] = 32'h280a00c8;
    pay[1] = 32'h28020001;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {63'b0, s_ready}, 64'd0);
    check({tag, "_we"},    {63'b0, mem_we},  64'd0);
    check({tag, "_addr"},  64'(mem_addr),    64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata),   64'd0);
    check({tag, "_run"},   {63'b0, cpu_run}, 64'd0);
    check({tag, "_busy"},  {63'b0, busy},    64'd0);
    check({tag, "_done"},  {63'b0, done},    64'd0);
    check({tag, "_err"},   {63'b0, err},     64'd0);
  endtask

  initial begin
    logic [15:0] ra;
    int          rn;
    logic [7:0]  flip;
    logic [41:0] w0;
    int          nw;

    // Reset values and the one-cycle s_ready hold-off after release.
    repeat (3) @(negedge clk1);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    check("ready_first_cycle", {63'b0, s_ready}, 64'd0);
    @(negedge clk1);
    check("ready_after", {63'b0, s_ready}, 64'd1);

    // Nominal load, then s_valid held high in DONE must not be accepted.
    set_nominal();
    run_load(16'h0000, 2, 8'h00, 0);
    nw = wq.size();
    s_valid = 1'b1;
    s_data  = 8'h55;
    for (int i = 0; i < 6; i++) begin
      check("done_no_ready", {63'b0, s_ready}, 64'd0);
      @(negedge clk1);
    end
    s_valid = 1'b0;
    check("done_hold", {63'b0, done}, 64'd1);
    check("done_no_write", 64'(wq.size()), 64'(nw));
    do_clear();

    // Bad checksum (c1 -> c0): writes happen, then ERR; clear recovers.
    run_load(16'h0000, 2, 8'h01, 0);
    do_clear();

    // Zero word count with correct and incorrect checksum.
    run_load(16'h0010, 0, 8'h00, 0);
    do_clear();
    run_load(16'h0010, 0, 8'h01, 0);
    do_clear();

    // Range error, then exact fit at the top of memory.
    run_load(16'h03ff, 2, 8'h00, 0);
    do_clear();
    pay[0] = $urandom();
    pay[1] = $urandom();
    run_load(16'h03fe, 2, 8'h00, 0);
    do_clear();

    // Nominal stream with random handshake gaps.
    set_nominal();
    run_load(16'h0000, 2, 8'h00, 5);
    do_clear();

    // Random images: addresses near and beyond the top, random corruption.
    for (int t = 0; t < 10; t++) begin
      ra   = (t % 2 == 0) ? 16'($urandom_range(1023, 0)) : 16'($urandom_range(1100, 1010));
      rn   = int'($urandom_range(6, 0));
      flip = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      for (int k = 0; k < 16; k++) pay[k] = $urandom();
      run_load(ra, rn, flip, 5);
      do_clear();
    end

    // Reset after word 0 and two bytes of word 1: partial word never written.
    set_nominal();
    wq.delete();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int j = 0; j < 4; j++) send_byte(pay[0][31 - 8*j -: 8], 0);
    send_byte(pay[1][31:24], 0);
    send_byte(pay[1][23:16], 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk1);
    w0 = (wq.size() > 0) ? wq[0] : '0;
    check("midrst_writes", 64'(wq.size()), 64'd1);
    check("midrst_word0", 64'(w0), {22'b0, 10'h000, 32'h280a00c8});
    run_load(16'h0000, 2, 8'h00, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
